ib_ram_bank_sched: RTL and testbench

Inbound RAM bank scheduler for the PCIe DMA inbound path: shares a set of NUM_BANKS inbound RAM banks between the AXI-stream producer (the write side) and the IPSec core (the read side). It accepts whole frames into free banks in round-robin order and generates per-beat write addressing. It hands filled banks to the consumer strictly in fill order, then reclaims each bank when the consumer signals completion. It replaces single-buffer valid/consumed sequencing with multi-bank ping-pong operation, so the producer never stalls while a free bank exists.

---
 rtl/ib_ram_bank_sched_if.sv | 29 ++
 rtl/ib_ram_bank_sched.sv | 107 ++++++++++
 tb/tb_ib_ram_bank_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ib_ram_bank_sched_if.sv
// Producer/consumer bus of the inbound RAM bank scheduler.
// The master modport is the environment side; the slave modport is the scheduler.
interface ib_ram_bank_sched_if #(
    parameter int NUM_BANKS = 2,
    parameter int BEAT_W    = 9
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [BEAT_W-1:0] wr_beat;
    logic              cons_valid;
    logic [BANK_W-1:0] cons_bank;
    logic [BEAT_W:0]   cons_beats;
    logic              cons_done;

    modport master (
        output s_tvalid, s_tlast, cons_done,
        input  s_tready, wr_en, wr_bank, wr_beat, cons_valid, cons_bank, cons_beats
    );

    modport slave (
        input  s_tvalid, s_tlast, cons_done,
        output s_tready, wr_en, wr_bank, wr_beat, cons_valid, cons_bank, cons_beats
    );
endinterface

// File: rtl/ib_ram_bank_sched.sv
// Inbound RAM bank scheduler: fills free banks round-robin from the producer
// and hands them to the consumer in fill order, reclaiming each on cons_done.
module ib_ram_bank_sched #(
    parameter int NUM_BANKS = 2,
    parameter int BEAT_W    = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           err_clr,
    ib_ram_bank_sched_if.slave             bus,
    output logic [$clog2(NUM_BANKS+1)-1:0] free_banks,
    output logic                           ovf_err
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int OCC_W  = $clog2(NUM_BANKS + 1);
    localparam logic [BEAT_W:0]  MAX_BEATS = {1'b1, {BEAT_W{1'b0}}};
    localparam logic [OCC_W-1:0] NB        = OCC_W'(NUM_BANKS);

    typedef enum logic {R_IDLE, R_PRESENT} rd_state_t;

    rd_state_t         rd_state, rd_next;
    logic [BANK_W-1:0] wp, rp;
    logic [OCC_W-1:0]  occ;
    logic              in_frame;
    logic [BEAT_W:0]   bcnt;
    logic [BEAT_W:0]   len [NUM_BANKS];
    logic              hs, at_max, frame_end, release_bank;

    // occ only rises at tlast, so a full stall can only hold off a frame start
    assign bus.s_tready = (occ < NB) && (in_frame || enable);
    assign hs           = bus.s_tvalid && bus.s_tready;
    assign at_max       = (bcnt == MAX_BEATS);
    assign frame_end    = hs && bus.s_tlast;
    assign bus.wr_en    = hs && !at_max;
    assign bus.wr_beat  = bcnt[BEAT_W-1:0];
    assign bus.wr_bank  = wp;
    assign free_banks   = NB - occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            bcnt     <= '0;
            in_frame <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) len[i] <= '0;
        end else if (hs) begin
            if (!at_max) bcnt <= bcnt + 1'b1;
            if (bus.s_tlast) begin
                len[wp]  <= at_max ? MAX_BEATS : bcnt + 1'b1;
                wp       <= wp + 1'b1;
                bcnt     <= '0;
                in_frame <= 1'b0;
            end else begin
                in_frame <= 1'b1;
            end
        end
    end

    // A beat beyond bank capacity sets the error even if err_clr is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ovf_err <= 1'b0;
        else if (hs && at_max)   ovf_err <= 1'b1;
        else if (err_clr)        ovf_err <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
            rp  <= '0;
        end else begin
            case ({frame_end, release_bank})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (release_bank) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= R_IDLE;
        else        rd_state <= rd_next;
    end

    // Returning to R_IDLE after each release forces a one-cycle bubble
    always_comb begin
        rd_next        = rd_state;
        release_bank   = 1'b0;
        bus.cons_valid = 1'b0;
        bus.cons_bank  = '0;
        bus.cons_beats = '0;
        case (rd_state)
            R_IDLE: begin
                if (occ != '0) rd_next = R_PRESENT;
            end
            R_PRESENT: begin
                bus.cons_valid = 1'b1;
                bus.cons_bank  = rp;
                bus.cons_beats = len[rp];
                if (bus.cons_done) begin
                    release_bank = 1'b1;
                    rd_next      = R_IDLE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_ib_ram_bank_sched.sv
// Directed bench for ib_ram_bank_sched with NUM_BANKS=2, BEAT_W=3 (MAX_BEATS=8).
module tb_ib_ram_bank_sched;
    localparam int NB = 2;
    localparam int BW = 3;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       err_clr;
    logic [1:0] free_banks;
    logic       ovf_err;
    int         checks = 0;
    int         errors = 0;

    ib_ram_bank_sched_if #(.NUM_BANKS(NB), .BEAT_W(BW)) bus ();

    ib_ram_bank_sched #(.NUM_BANKS(NB), .BEAT_W(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .err_clr    (err_clr),
        .bus        (bus),
        .free_banks (free_banks),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic last, input logic done, input logic clr);
        bus.s_tvalid  = valid;
        bus.s_tlast   = last;
        bus.cons_done = done;
        err_clr       = clr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.s_tvalid  = 1'b0;
        bus.s_tlast   = 1'b0;
        bus.cons_done = 1'b0;
        err_clr       = 1'b0;
    endtask

    // Presents one producer beat and checks the write addressing it produces
    task automatic beat(input string tag, input logic last, input logic done,
                        input logic exp_we, input int exp_beat, input int exp_bank);
        applyStimulus(1'b1, last, done, 1'b0);
        checkOutput({tag, "_rdy"},  32'(bus.s_tready), 32'd1);
        checkOutput({tag, "_we"},   32'(bus.wr_en),    32'(exp_we));
        checkOutput({tag, "_beat"}, 32'(bus.wr_beat),  32'(exp_beat));
        checkOutput({tag, "_bank"}, 32'(bus.wr_bank),  32'(exp_bank));
        step();
    endtask

    task automatic checkCons(input string tag, input logic valid, input int bank, input int beats);
        checkOutput({tag, "_cv"}, 32'(bus.cons_valid), 32'(valid));
        if (valid) begin
            checkOutput({tag, "_cb"}, 32'(bus.cons_bank),  32'(bank));
            checkOutput({tag, "_cn"}, 32'(bus.cons_beats), 32'(beats));
        end
    endtask

    // Asserts reset with idle inputs, checks reset values, then releases it
    task automatic resetDut(input string tag);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_rdy"},  32'(bus.s_tready),   32'(enable));
        checkOutput({tag, "_we"},   32'(bus.wr_en),      32'd0);
        checkOutput({tag, "_bank"}, 32'(bus.wr_bank),    32'd0);
        checkOutput({tag, "_beat"}, 32'(bus.wr_beat),    32'd0);
        checkOutput({tag, "_cv"},   32'(bus.cons_valid), 32'd0);
        checkOutput({tag, "_cb"},   32'(bus.cons_bank),  32'd0);
        checkOutput({tag, "_cn"},   32'(bus.cons_beats), 32'd0);
        checkOutput({tag, "_free"}, 32'(free_banks),     32'd2);
        checkOutput({tag, "_ovf"},  32'(ovf_err),        32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        enable = 1'b1;
        rst_n  = 1'b0;
        bus.s_tvalid  = 1'b0;
        bus.s_tlast   = 1'b0;
        bus.cons_done = 1'b0;
        err_clr       = 1'b0;
        #1;
        resetDut("rst0");

        // Single 4-beat frame into bank 0
        beat("f4b0", 1'b0, 1'b0, 1'b1, 0, 0);
        beat("f4b1", 1'b0, 1'b0, 1'b1, 1, 0);
        beat("f4b2", 1'b0, 1'b0, 1'b1, 2, 0);
        beat("f4b3", 1'b1, 1'b0, 1'b1, 3, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("f4t1", 1'b0, 0, 0);
        checkOutput("f4t1_free", 32'(free_banks), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkCons("f4t2", 1'b1, 0, 4);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("f4t3", 1'b0, 0, 0);
        checkOutput("f4t3_free", 32'(free_banks), 32'd2);

        // Three back-to-back 2-beat frames; the third waits for a free bank
        resetDut("rst1");
        beat("bbA0", 1'b0, 1'b0, 1'b1, 0, 0);
        beat("bbA1", 1'b1, 1'b0, 1'b1, 1, 0);
        beat("bbB0", 1'b0, 1'b0, 1'b1, 0, 1);
        beat("bbB1", 1'b1, 1'b0, 1'b1, 1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bb_full_rdy",  32'(bus.s_tready), 32'd0);
        checkOutput("bb_full_we",   32'(bus.wr_en),    32'd0);
        checkOutput("bb_full_free", 32'(free_banks),   32'd0);
        checkCons("bb_full", 1'b1, 0, 2);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("bb_done_rdy", 32'(bus.s_tready), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("bb_bubble", 1'b0, 0, 0);
        beat("bbC0", 1'b0, 1'b0, 1'b1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("bbC1", 1'b1, 1, 2);
        beat("bbC1", 1'b1, 1'b0, 1'b1, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkCons("bb_p1", 1'b1, 1, 2);
        checkOutput("bb_p1_free", 32'(free_banks), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("bb_gap", 1'b0, 0, 0);
        checkOutput("bb_gap_free", 32'(free_banks), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkCons("bb_p0", 1'b1, 0, 2);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bb_end_free", 32'(free_banks), 32'd2);

        // Frames of 1, 7 and 3 beats drained in fill order
        resetDut("rst2");
        beat("d1", 1'b1, 1'b0, 1'b1, 0, 0);
        for (int k = 0; k < 7; k++) beat("d7", k == 6, 1'b0, 1'b1, k, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkCons("d_p0", 1'b1, 0, 1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("d_gap0", 1'b0, 0, 0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkCons("d_p1", 1'b1, 1, 7);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("d_free", 32'(free_banks), 32'd2);
        for (int k = 0; k < 3; k++) beat("d3", k == 2, 1'b0, 1'b1, k, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("d_gap1", 1'b0, 0, 0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkCons("d_p2", 1'b1, 0, 3);
        step();

        // Oversize frame of 10 beats into an 8-beat bank
        resetDut("rst3");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, k == 9, 1'b0, 1'b0);
            checkOutput("ov_rdy",  32'(bus.s_tready), 32'd1);
            checkOutput("ov_we",   32'(bus.wr_en),    32'(k < 8));
            checkOutput("ov_beat", 32'(bus.wr_beat),  32'(k < 8 ? k : 0));
            checkOutput("ov_err",  32'(ovf_err),      32'(k == 9));
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ov_t1_err", 32'(ovf_err), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkCons("ov_p", 1'b1, 0, 8);
        checkOutput("ov_clr_err", 32'(ovf_err), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ov_cleared", 32'(ovf_err),    32'd0);
        checkOutput("ov_free",    32'(free_banks), 32'd2);

        // tlast handshake in the same cycle as cons_done at occ=1
        resetDut("rst4");
        beat("coA0", 1'b0, 1'b0, 1'b1, 0, 0);
        beat("coA1", 1'b1, 1'b0, 1'b1, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("coT1", 1'b0, 0, 0);
        beat("coB0", 1'b0, 1'b0, 1'b1, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("coT2", 1'b1, 0, 2);
        beat("coB1", 1'b1, 1'b1, 1'b1, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("co_bubble", 1'b0, 0, 0);
        checkOutput("co_free", 32'(free_banks),  32'd1);
        checkOutput("co_wp",   32'(bus.wr_bank), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkCons("co_p1", 1'b1, 1, 2);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("co_end_free", 32'(free_banks), 32'd2);

        // enable dropped mid-frame, then reset mid-frame with a bank presented
        resetDut("rst5");
        beat("en0", 1'b0, 1'b0, 1'b1, 0, 0);
        beat("en1", 1'b0, 1'b0, 1'b1, 1, 0);
        enable = 1'b0;
        beat("en2", 1'b0, 1'b0, 1'b1, 2, 0);
        beat("en3", 1'b0, 1'b0, 1'b1, 3, 0);
        beat("en4", 1'b1, 1'b0, 1'b1, 4, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("en_hold_rdy", 32'(bus.s_tready), 32'd0);
        checkOutput("en_hold_we",  32'(bus.wr_en),    32'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("en_hold2_rdy", 32'(bus.s_tready), 32'd0);
        checkCons("en_p", 1'b1, 0, 5);
        step();
        enable = 1'b1;
        beat("en_n0", 1'b0, 1'b0, 1'b1, 0, 1);
        beat("en_n1", 1'b0, 1'b0, 1'b1, 1, 1);
        resetDut("rst_mid");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_bank", 32'(bus.wr_bank), 32'd0);
        checkOutput("post_rst_beat", 32'(bus.wr_beat), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkCons("post_rst_cv", 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
